// File: rtl/rx_bit_timer_p_if.sv
// rtl/rx_bit_timer_p_if.sv - RX FSM <-> bit timer signal bundle
// Master is the RX FSM side, slave is the bit timer.
interface rx_bit_timer_p_if #(
   parameter int CNT_W = 16,
   parameter int IDX_W = 4
);
   logic             enable;
   logic [CNT_W-1:0] divisor;
   logic [IDX_W-1:0] frame_bits;
   logic             rx_in;
   logic             sample_tick;
   logic             bit_val;
   logic [IDX_W-1:0] bit_idx;
   logic             frame_done;
   logic             false_start;
   logic             busy;

   modport master (
      output enable, divisor, frame_bits, rx_in,
      input  sample_tick, bit_val, bit_idx, frame_done, false_start, busy
   );

   modport slave (
      input  enable, divisor, frame_bits, rx_in,
      output sample_tick, bit_val, bit_idx, frame_done, false_start, busy
   );
endinterface

// File: rtl/rx_bit_timer_p.sv
// rtl/rx_bit_timer_p.sv - UART RX bit-centre sample timer
// Validates the start bit at its centre, then strobes the centre of each bit.
module rx_bit_timer_p #(
   parameter int CNT_W = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rx_arst_n,
   input  logic             rx_rst,
   rx_bit_timer_p_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HALF = 2'd1;
   localparam logic [1:0] ST_BIT  = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_div;
   logic [IDX_W-1:0] r_nbits;
   logic             r_sample_tick;
   logic             r_bit_val;
   logic [IDX_W-1:0] r_bit_idx;
   logic             r_frame_done;
   logic             r_false_start;
   logic             r_busy;

   logic [CNT_W-1:0] w_div_clamp;
   logic [IDX_W-1:0] w_nbits_clamp;
   logic [CNT_W-1:0] w_half_init;

   // Clamp keeps the half period at least one count so cnt never wraps
   always_comb begin
      w_div_clamp   = (bus.divisor < CNT_W'(4)) ? CNT_W'(4) : bus.divisor;
      w_nbits_clamp = (bus.frame_bits < IDX_W'(2)) ? IDX_W'(2) : bus.frame_bits;
      w_half_init   = (w_div_clamp >> 1) - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rx_arst_n) begin
      if (!rx_arst_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_div         <= '0;
         r_nbits       <= '0;
         r_sample_tick <= 1'b0;
         r_bit_val     <= 1'b0;
         r_bit_idx     <= '0;
         r_frame_done  <= 1'b0;
         r_false_start <= 1'b0;
         r_busy        <= 1'b0;
      end else if (rx_rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_div         <= '0;
         r_nbits       <= '0;
         r_sample_tick <= 1'b0;
         r_bit_val     <= 1'b0;
         r_bit_idx     <= '0;
         r_frame_done  <= 1'b0;
         r_false_start <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_sample_tick <= 1'b0;
         r_frame_done  <= 1'b0;
         r_false_start <= 1'b0;
         if (!bus.enable) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_div   <= w_div_clamp;
                  r_nbits <= w_nbits_clamp;
                  r_cnt   <= w_half_init;
                  r_idx   <= '0;
                  r_state <= ST_HALF;
                  r_busy  <= 1'b1;
               end
               ST_HALF: begin
                  if (r_cnt == '0) begin
                     r_sample_tick <= 1'b1;
                     r_bit_idx     <= '0;
                     r_bit_val     <= bus.rx_in;
                     if (bus.rx_in) begin
                        r_false_start <= 1'b1;
                        r_state       <= ST_HOLD;
                        r_busy        <= 1'b0;
                     end else begin
                        r_cnt   <= r_div - CNT_W'(1);
                        r_idx   <= IDX_W'(1);
                        r_state <= ST_BIT;
                     end
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               ST_BIT: begin
                  if (r_cnt == '0) begin
                     r_sample_tick <= 1'b1;
                     r_bit_idx     <= r_idx;
                     r_bit_val     <= bus.rx_in;
                     if (r_idx == r_nbits - IDX_W'(1)) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_HOLD;
                        r_busy       <= 1'b0;
                     end else begin
                        r_idx <= r_idx + IDX_W'(1);
                        r_cnt <= r_div - CNT_W'(1);
                     end
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               ST_HOLD: begin
                  r_state <= ST_HOLD;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.sample_tick = r_sample_tick;
   assign bus.bit_val     = r_bit_val;
   assign bus.bit_idx     = r_bit_idx;
   assign bus.frame_done  = r_frame_done;
   assign bus.false_start = r_false_start;
   assign bus.busy        = r_busy;

endmodule

// File: tb/tb_rx_bit_timer_p.sv
// tb/tb_rx_bit_timer_p.sv - directed self-checking bench for rx_bit_timer_p
// Cycle c counts clock edges after E0; outputs are sampled 1 time unit after each edge.
module tb_rx_bit_timer_p;

   logic clk;
   logic rx_arst_n;
   logic rx_rst;
   int   n_checks;
   int   n_errors;
   logic [15:0] frame1;
   bit   exp_t;

   rx_bit_timer_p_if #(.CNT_W(16), .IDX_W(4)) bus_if ();

   rx_bit_timer_p #(.CNT_W(16), .IDX_W(4)) dut (
      .clk       (clk),
      .rx_arst_n (rx_arst_n),
      .rx_rst    (rx_rst),
      .bus       (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " tick"}, 32'(bus_if.sample_tick), 32'd0);
      check({tag, " val"},  32'(bus_if.bit_val),     32'd0);
      check({tag, " idx"},  32'(bus_if.bit_idx),     32'd0);
      check({tag, " done"}, 32'(bus_if.frame_done),  32'd0);
      check({tag, " fs"},   32'(bus_if.false_start), 32'd0);
      check({tag, " busy"}, 32'(bus_if.busy),        32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      // frame: start 0, data 0x55 LSB-first, stop 1, idle high beyond
      frame1 = 16'hFEAA;
      rx_arst_n = 1'b0;
      rx_rst = 1'b0;
      bus_if.enable = 1'b0;
      bus_if.divisor = 16'd16;
      bus_if.frame_bits = 4'd10;
      bus_if.rx_in = 1'b1;
      step();
      step();
      check_all_zero("reset");
      rx_arst_n = 1'b1;
      step();
      check_all_zero("idle");

      // Test 1: D=16 N=10, 0x55 payload
      bus_if.rx_in = 1'b0;
      bus_if.enable = 1'b1;
      step();
      check("t1 busy rise", 32'(bus_if.busy), 32'd1);
      bus_if.divisor = 16'd5;
      bus_if.frame_bits = 4'd3;
      bus_if.rx_in = frame1[0];
      for (int c = 1; c <= 170; c++) begin
         step();
         exp_t = (c >= 8) && ((c - 8) % 16 == 0) && ((c - 8) / 16 <= 9);
         check("t1 tick", 32'(bus_if.sample_tick), 32'(exp_t));
         if (exp_t) begin
            check("t1 idx", 32'(bus_if.bit_idx), 32'((c - 8) / 16));
            check("t1 val", 32'(bus_if.bit_val), 32'(frame1[(c - 8) / 16]));
         end
         check("t1 done", 32'(bus_if.frame_done), 32'(c == 152));
         check("t1 busy", 32'(bus_if.busy), 32'(c < 152));
         check("t1 fs", 32'(bus_if.false_start), 32'd0);
         bus_if.rx_in = frame1[(c + 1) / 16];
      end

      // Test 2: false start, line back high 3 cycles after E0
      bus_if.enable = 1'b0;
      bus_if.divisor = 16'd16;
      bus_if.frame_bits = 4'd10;
      bus_if.rx_in = 1'b0;
      step();
      check("t2 idle busy", 32'(bus_if.busy), 32'd0);
      bus_if.enable = 1'b1;
      step();
      for (int c = 1; c <= 40; c++) begin
         if (c == 3) bus_if.rx_in = 1'b1;
         step();
         check("t2 tick", 32'(bus_if.sample_tick), 32'(c == 8));
         check("t2 fs", 32'(bus_if.false_start), 32'(c == 8));
         check("t2 busy", 32'(bus_if.busy), 32'(c < 8));
         check("t2 done", 32'(bus_if.frame_done), 32'd0);
         if (c == 8) begin
            check("t2 val", 32'(bus_if.bit_val), 32'd1);
            check("t2 idx", 32'(bus_if.bit_idx), 32'd0);
         end
      end

      // Test 3: D=10416, first two bit centres
      bus_if.enable = 1'b0;
      bus_if.divisor = 16'd10416;
      bus_if.rx_in = 1'b0;
      step();
      bus_if.enable = 1'b1;
      step();
      for (int c = 1; c <= 15630; c++) begin
         step();
         exp_t = (c == 5208) || (c == 15624);
         check("t3 tick", 32'(bus_if.sample_tick), 32'(exp_t));
         if (exp_t) check("t3 idx", 32'(bus_if.bit_idx), 32'(c == 15624));
      end
      check("t3 busy", 32'(bus_if.busy), 32'd1);

      // Test 4: abort on bit 2 centre edge, then back-to-back restart
      bus_if.enable = 1'b0;
      bus_if.divisor = 16'd16;
      step();
      bus_if.enable = 1'b1;
      step();
      for (int c = 1; c <= 39; c++) begin
         step();
         check("t4 tick", 32'(bus_if.sample_tick), 32'((c == 8) || (c == 24)));
      end
      bus_if.enable = 1'b0;
      step();
      check("t4 abort tick", 32'(bus_if.sample_tick), 32'd0);
      check("t4 abort busy", 32'(bus_if.busy), 32'd0);
      check("t4 abort idx", 32'(bus_if.bit_idx), 32'd1);
      bus_if.enable = 1'b1;
      step();
      check("t4 re busy", 32'(bus_if.busy), 32'd1);
      for (int c = 1; c <= 30; c++) begin
         step();
         exp_t = (c == 8) || (c == 24);
         check("t4 re tick", 32'(bus_if.sample_tick), 32'(exp_t));
         if (exp_t) check("t4 re idx", 32'(bus_if.bit_idx), 32'(c == 24));
      end

      // Test 5: divisor=2 frame_bits=1 clamp to D=4 N=2
      bus_if.enable = 1'b0;
      bus_if.divisor = 16'd2;
      bus_if.frame_bits = 4'd1;
      bus_if.rx_in = 1'b0;
      step();
      bus_if.enable = 1'b1;
      step();
      for (int c = 1; c <= 20; c++) begin
         step();
         exp_t = (c == 2) || (c == 6);
         check("t5 tick", 32'(bus_if.sample_tick), 32'(exp_t));
         check("t5 done", 32'(bus_if.frame_done), 32'(c == 6));
         check("t5 busy", 32'(bus_if.busy), 32'(c < 6));
         if (exp_t) begin
            check("t5 idx", 32'(bus_if.bit_idx), 32'(c == 6));
            check("t5 val", 32'(bus_if.bit_val), 32'(c == 6));
         end
         if (c == 2) bus_if.rx_in = 1'b1;
      end

      // Test 6a: synchronous clear landing on a tick edge
      bus_if.enable = 1'b0;
      bus_if.divisor = 16'd16;
      bus_if.frame_bits = 4'd10;
      bus_if.rx_in = 1'b0;
      step();
      bus_if.enable = 1'b1;
      step();
      for (int c = 1; c <= 7; c++) step();
      check("t6 pre busy", 32'(bus_if.busy), 32'd1);
      rx_rst = 1'b1;
      step();
      check_all_zero("t6 rx_rst");
      rx_rst = 1'b0;
      bus_if.enable = 1'b0;
      step();
      bus_if.enable = 1'b1;
      step();
      for (int c = 1; c <= 29; c++) begin
         step();
         exp_t = (c == 8) || (c == 24);
         check("t6 tick", 32'(bus_if.sample_tick), 32'(exp_t));
         if (exp_t) check("t6 idx", 32'(bus_if.bit_idx), 32'(c == 24));
         if (c == 8) bus_if.rx_in = 1'b1;
      end
      check("t6 held val", 32'(bus_if.bit_val), 32'd1);

      // Test 6b: asynchronous reset mid-frame, then clean restart
      #3;
      rx_arst_n = 1'b0;
      #1;
      check_all_zero("t6 arst");
      step();
      rx_arst_n = 1'b1;
      bus_if.enable = 1'b0;
      bus_if.rx_in = 1'b0;
      step();
      bus_if.enable = 1'b1;
      step();
      for (int c = 1; c <= 10; c++) begin
         step();
         check("t6 new tick", 32'(bus_if.sample_tick), 32'(c == 8));
         check("t6 new busy", 32'(bus_if.busy), 32'd1);
         if (c == 8) check("t6 new idx", 32'(bus_if.bit_idx), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
